// File: rtl/clz_normalizer_if.sv
// Handshake/data bundle for clz_normalizer; the mode signal exists only when
// CLZ_NORMALIZER_CTZ_EN is defined.
interface clz_normalizer_if #(
  parameter int WIDTH = 32
);
  localparam int LZW = $clog2(WIDTH) + 1;

  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] din;
  logic             out_valid;
  logic             out_ready;
  logic [LZW-1:0]   lzc;
  logic [WIDTH-1:0] norm;
  logic             zero;
`ifdef CLZ_NORMALIZER_CTZ_EN
  logic             mode;
`endif

  modport master (
    output in_valid, din, out_ready,
`ifdef CLZ_NORMALIZER_CTZ_EN
    output mode,
`endif
    input  in_ready, out_valid, lzc, norm, zero
  );

  modport slave (
    input  in_valid, din, out_ready,
`ifdef CLZ_NORMALIZER_CTZ_EN
    input  mode,
`endif
    output in_ready, out_valid, lzc, norm, zero
  );
endinterface

// File: rtl/clz_normalizer.sv
// Sequential leading-zero counter / normalizer, one byte slice per cycle.
// Define CLZ_NORMALIZER_CTZ_EN to add a trailing-zero mode (bus.mode=1).
//
// state | meaning
// IDLE  | waiting for a word, in_ready=1
// SCAN  | testing byte k for a set bit
// SHIFT | computing count and shifted word
// DONE  | result presented until out_ready
module clz_normalizer #(
  parameter int WIDTH = 32
) (
  input logic            clk,
  input logic            rst_n,
  clz_normalizer_if.slave bus
);
  localparam int NB  = WIDTH / 8;
  localparam int LZW = $clog2(WIDTH) + 1;
  localparam int KW  = (NB > 1) ? $clog2(NB) : 1;

  typedef enum logic [1:0] {IDLE, SCAN, SHIFT, DONE} state_t;

  state_t           state_q, state_d;
  logic [WIDTH-1:0] data_q, data_d;
  logic [KW-1:0]    k_q, k_d;
  logic [2:0]       p_q, p_d;
  logic [LZW-1:0]   lzc_q, lzc_d;
  logic [WIDTH-1:0] norm_q, norm_d;
  logic             zero_q, zero_d;
  logic             ctz;

  // Distance of the highest set bit from bit 7.
  function automatic logic [2:0] msb_pos(input logic [7:0] b);
    logic [2:0] r;
    r = 3'd0;
    for (int i = 0; i < 8; i++) if (b[i]) r = 3'(7 - i);
    return r;
  endfunction

`ifdef CLZ_NORMALIZER_CTZ_EN
  logic mode_q, mode_d;

  function automatic logic [2:0] lsb_pos(input logic [7:0] b);
    logic [2:0] r;
    r = 3'd0;
    for (int i = 7; i >= 0; i--) if (b[i]) r = 3'(i);
    return r;
  endfunction

  assign ctz = mode_q;
`else
  assign ctz = 1'b0;
`endif

  always_comb begin
    logic [7:0] cur;
    logic       last;
    int         cnt;
    state_d = state_q;
    data_d  = data_q;
    k_d     = k_q;
    p_d     = p_q;
    lzc_d   = lzc_q;
    norm_d  = norm_q;
    zero_d  = zero_q;
`ifdef CLZ_NORMALIZER_CTZ_EN
    mode_d  = mode_q;
`endif
    cur  = data_q[int'(k_q)*8 +: 8];
    last = ctz ? (k_q == KW'(NB - 1)) : (k_q == '0);
    cnt  = 0;
    case (state_q)
      IDLE: begin
        if (bus.in_valid) begin
          data_d  = bus.din;
          k_d     = KW'(NB - 1);
          state_d = SCAN;
`ifdef CLZ_NORMALIZER_CTZ_EN
          mode_d  = bus.mode;
          if (bus.mode) k_d = '0;
`endif
        end
      end
      SCAN: begin
        if (cur != 8'd0) begin
`ifdef CLZ_NORMALIZER_CTZ_EN
          p_d = ctz ? lsb_pos(cur) : msb_pos(cur);
`else
          p_d = msb_pos(cur);
`endif
          state_d = SHIFT;
        end else if (last) begin
          lzc_d   = LZW'(WIDTH);
          norm_d  = '0;
          zero_d  = 1'b1;
          state_d = DONE;
        end else begin
          k_d = ctz ? k_q + KW'(1) : k_q - KW'(1);
        end
      end
      SHIFT: begin
        if (ctz) begin
          cnt    = int'(k_q) * 8 + int'(p_q);
          norm_d = data_q >> cnt;
        end else begin
          cnt    = (NB - 1 - int'(k_q)) * 8 + int'(p_q);
          norm_d = data_q << cnt;
        end
        lzc_d   = LZW'(cnt);
        zero_d  = 1'b0;
        state_d = DONE;
      end
      DONE: begin
        if (bus.out_ready) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      data_q  <= '0;
      k_q     <= '0;
      p_q     <= '0;
      lzc_q   <= '0;
      norm_q  <= '0;
      zero_q  <= 1'b0;
`ifdef CLZ_NORMALIZER_CTZ_EN
      mode_q  <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      data_q  <= data_d;
      k_q     <= k_d;
      p_q     <= p_d;
      lzc_q   <= lzc_d;
      norm_q  <= norm_d;
      zero_q  <= zero_d;
`ifdef CLZ_NORMALIZER_CTZ_EN
      mode_q  <= mode_d;
`endif
    end
  end

  assign bus.in_ready  = (state_q == IDLE);
  assign bus.out_valid = (state_q == DONE);
  assign bus.lzc       = lzc_q;
  assign bus.norm      = norm_q;
  assign bus.zero      = zero_q;
endmodule

// File: tb/tb_clz_normalizer.sv
// Directed bench for clz_normalizer: latency, results, backpressure, reset.
module tb_clz_normalizer;
  logic clk;
  logic rst_n;
  int   total = 0;
  int   bad   = 0;

  clz_normalizer_if #(.WIDTH(32)) bus ();

  clz_normalizer #(.WIDTH(32)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp)
    else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Send one word, measure latency (accept edge counts as 1), check result,
  // hold off out_ready for 'hold' cycles, then hand off.
  task automatic run(input string tag, input logic [31:0] d, input logic m,
                     input int exp_lat, input logic [5:0] exp_lzc,
                     input logic [31:0] exp_norm, input logic exp_zero,
                     input int hold);
    int cyc;
    chk({tag, "_in_ready_idle"}, 64'(bus.in_ready), 64'd1);
    bus.din      = d;
    bus.in_valid = 1'b1;
`ifdef CLZ_NORMALIZER_CTZ_EN
    bus.mode     = m;
`endif
    @(posedge clk); #1;
    bus.in_valid = 1'b0;
    cyc = 1;
    while (!bus.out_valid && cyc < 40) begin
      @(posedge clk); #1;
      cyc++;
    end
    chk({tag, "_latency"}, 64'(cyc), 64'(exp_lat));
    chk({tag, "_lzc"}, 64'(bus.lzc), 64'(exp_lzc));
    chk({tag, "_norm"}, 64'(bus.norm), 64'(exp_norm));
    chk({tag, "_zero"}, 64'(bus.zero), 64'(exp_zero));
    chk({tag, "_in_ready_busy"}, 64'(bus.in_ready), 64'd0);
    for (int i = 0; i < hold; i++) begin
      @(posedge clk); #1;
      chk({tag, "_hold_valid"}, 64'(bus.out_valid), 64'd1);
      chk({tag, "_hold_norm"}, 64'(bus.norm), 64'(exp_norm));
      chk({tag, "_hold_in_ready"}, 64'(bus.in_ready), 64'd0);
    end
    bus.out_ready = 1'b1;
    @(posedge clk); #1;
    bus.out_ready = 1'b0;
    chk({tag, "_after_valid"}, 64'(bus.out_valid), 64'd0);
    chk({tag, "_after_in_ready"}, 64'(bus.in_ready), 64'd1);
    chk({tag, "_after_lzc_kept"}, 64'(bus.lzc), 64'(exp_lzc));
  endtask

  initial begin
    bit seen;
    rst_n         = 1'b0;
    bus.in_valid  = 1'b0;
    bus.din       = '0;
    bus.out_ready = 1'b0;
`ifdef CLZ_NORMALIZER_CTZ_EN
    bus.mode      = 1'b0;
`endif
    repeat (3) @(posedge clk);
    #1;
    chk("rst_in_ready", 64'(bus.in_ready), 64'd1);
    chk("rst_out_valid", 64'(bus.out_valid), 64'd0);
    chk("rst_lzc", 64'(bus.lzc), 64'd0);
    chk("rst_norm", 64'(bus.norm), 64'd0);
    chk("rst_zero", 64'(bus.zero), 64'd0);
    rst_n = 1'b1;
    @(posedge clk); #1;

    run("msb",    32'h8000_0000, 1'b0, 3, 6'd0,  32'h8000_0000, 1'b0, 0);
    run("mid",    32'h0001_2345, 1'b0, 4, 6'd15, 32'h91A2_8000, 1'b0, 0);

    // Reset while scanning: state and outputs clear at once, no result later.
    bus.din      = 32'h0001_2345;
    bus.in_valid = 1'b1;
    @(posedge clk); #1;
    bus.in_valid = 1'b0;
    @(posedge clk); #1;
    rst_n = 1'b0;
    #1;
    chk("midrst_out_valid", 64'(bus.out_valid), 64'd0);
    chk("midrst_in_ready", 64'(bus.in_ready), 64'd1);
    chk("midrst_lzc", 64'(bus.lzc), 64'd0);
    chk("midrst_norm", 64'(bus.norm), 64'd0);
    @(posedge clk); #1;
    rst_n = 1'b1;
    seen = 1'b0;
    repeat (8) begin
      @(posedge clk); #1;
      if (bus.out_valid) seen = 1'b1;
    end
    chk("midrst_no_result", 64'(seen), 64'd0);
    chk("midrst_idle", 64'(bus.in_ready), 64'd1);

    run("lsb_bp", 32'h0000_0001, 1'b0, 6, 6'd31, 32'h8000_0000, 1'b0, 5);
    run("allz",   32'h0000_0000, 1'b0, 5, 6'd32, 32'h0000_0000, 1'b1, 0);
    run("b2b",    32'h00FF_0000, 1'b0, 4, 6'd8,  32'hFF00_0000, 1'b0, 0);
    run("low",    32'h0000_7F00, 1'b0, 5, 6'd17, 32'hFE00_0000, 1'b0, 1);
`ifdef CLZ_NORMALIZER_CTZ_EN
    run("ctz",      32'h0001_2340, 1'b1, 3, 6'd6,  32'h0000_048D, 1'b0, 0);
    run("ctz_msb",  32'h8000_0000, 1'b1, 6, 6'd31, 32'h0000_0001, 1'b0, 0);
    run("ctz_zero", 32'h0000_0000, 1'b1, 5, 6'd32, 32'h0000_0000, 1'b1, 0);
    run("clz_mode0", 32'h0001_2345, 1'b0, 4, 6'd15, 32'h91A2_8000, 1'b0, 0);
`endif

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/clz_normalizer.md
Name: clz_normalizer

Overview:
- Sequential leading-zero counter and normalizer. It is the inverse of the one-hot diagonal shifter: it takes a data word, finds the shift amount that puts the leading one at the MSB, and returns the normalized word.
- Scans one 8-bit slice per cycle from the MSB byte down, then does one shift cycle.
- Sits beside the ALU shift path and feeds CLZ/normalize results back through a valid/ready handshake.

Parameters:
- WIDTH, 32, data width in bits; must be a multiple of 8 and at least 8.
- NB, WIDTH/8, number of byte slices (derived; do not override).
- LZW, $clog2(WIDTH)+1, width of the count output; wide enough to hold WIDTH.

Ports:
- clk  input  1  clock, all state changes on the rising edge.
- rst_n  input  1  asynchronous, active-low reset.
- in_valid  input  1  input word present.
- in_ready  output  1  block can accept a word; high only in IDLE.
- din  input  WIDTH  word to scan.
- out_valid  output  1  result present; held until taken.
- out_ready  input  1  consumer takes the result.
- lzc  output  LZW  zero count (leading zeros, or trailing zeros in CTZ mode).
- norm  output  WIDTH  normalized word.
- zero  output  1  din was all zeros.

Behaviour:
- Reset (rst_n low, asynchronous):
  - state goes to IDLE.
  - in_ready=1, out_valid=0, lzc=0, norm=0, zero=0.
  - Internal data, index and position registers are cleared.
  - Reset mid-scan or mid-DONE abandons the word with no output.
- States: IDLE, SCAN, SHIFT, DONE.
- IDLE:
  - in_ready=1.
  - On in_valid&&in_ready: latch din, set byte index k=NB-1, go to SCAN.
- SCAN (one byte per cycle, byte k = data[8k+7:8k]):
  - Byte k nonzero: capture the position p of its highest set bit (priority encode, 0..7, counted from bit 7), latch k, go to SHIFT.
  - Byte k zero and k==0: set lzc=WIDTH, norm=0, zero=1, go to DONE.
  - Otherwise: k=k-1, stay in SCAN.
- SHIFT (one cycle):
  - lzc = (NB-1-k)*8 + p.
  - norm = data << lzc.
  - zero=0.
  - Go to DONE.
- DONE:
  - out_valid=1; lzc, norm and zero are held stable.
  - On out_ready: out_valid falls at the next edge, go to IDLE.
  - out_ready low holds indefinitely (backpressure); in_ready stays 0 the whole time.
- Latency (N = bytes examined):
  - Nonzero word: out_valid asserted N+2 cycles after the accept edge.
  - All-zero word: NB+1 cycles.
- Throughput: one word per (latency+1) cycles minimum. There is no overlap, because IDLE is needed to accept.
- Output registers change only on entering DONE. They keep their last value after handoff until the next DONE.
- Arithmetic:
  - lzc is unsigned LZW bits; its maximum is WIDTH.
  - The left shift fills zeros.
  - The MSB of norm is 1 whenever zero=0.

Optional Feature:
- Macro: CLZ_NORMALIZER_CTZ_EN.
- Defined:
  - Add input port mode (1 bit), sampled at accept.
  - mode=1 selects count-trailing-zeros:
    - Scan starts at k=0 and increments.
    - p is the lowest set bit within the byte.
    - lzc = 8k + p.
    - norm = data >> lzc with zero fill, so bit 0 of norm is 1.
    - An all-zero word ends after the scan of k=NB-1 with lzc=WIDTH, norm=0, zero=1.
  - mode=0 behaves exactly as the base block.
- Undefined: there is no mode port, and only the leading-zero path is built.

Test Plan:
- Reset during SCAN of 0x00012345 (rst_n low for 1 cycle) -> out_valid=0, in_ready=1, lzc=0, norm=0 immediately; no result appears afterwards.
- din=0x80000000 -> out_valid 3 cycles after accept; lzc=0, norm=0x80000000, zero=0.
- din=0x00012345 -> out_valid 4 cycles after accept; lzc=15, norm=0x91A28000, zero=0.
- din=0x00000001 with out_ready held low 5 cycles -> out_valid at cycle 6 and stays high; lzc=31, norm=0x80000000 stable; in_ready=0 until handoff; returns to IDLE on the cycle after out_ready=1.
- din=0x00000000 -> out_valid 5 cycles after accept; lzc=32, norm=0, zero=1; the next word is accepted back-to-back after handoff.
- CTZ_EN build, mode=1, din=0x00012340 -> out_valid 3 cycles after accept; lzc=6, norm=0x0000048D, zero=0.
